load_store_unit: RTL and testbench

Memory-stage initiator for the 24-bit data memory: accepts load/store requests from the pipeline over a valid/ready handshake, and drives the memory's `memWrite`/`memRead`/`address`/`write_data` port. It captures `read_data` for loads. Stores are posted into a small in-order store buffer and drained to memory on idle port cycles. Loads take priority on the single memory port and are checked against buffered stores for ordering.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/store_buffer.sv | 75 +++++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned MATCH_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    StIdle,
    StFence
  } fence_state_e;

endpackage

// File: rtl/store_buffer.sv
// In-order circular store buffer with a youngest-match address lookup.
module store_buffer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned MATCH_W  = 12,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   idx;

  assign full      = (count_q == CntW'(SB_DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // Pointer, count and storage update; push and pop together keep count steady.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= push_addr;
        data_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Walk live entries oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) &&
          (addr_q[idx][MATCH_W-1:0] == lookup_addr[MATCH_W-1:0])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator with a posted store buffer and fence.
// Optional feature: define LSU_STORE_FWD_EN to answer aliasing loads from the
// store buffer; otherwise such loads are held until the alias has drained.
module load_store_unit #(
  parameter int unsigned DATA_W   = lsu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = lsu_pkg::ADDR_W,
  parameter int unsigned MATCH_W  = lsu_pkg::MATCH_W,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              drain_req,
  output logic              sb_busy,
  output logic              memWrite,
  output logic              memRead,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  import lsu_pkg::*;

  fence_state_e      state_q, state_d;
  logic              full, empty, hit;
  logic [DATA_W-1:0] hit_data, head_data, load_data;
  logic [ADDR_W-1:0] head_addr;
  logic              fence_active, store_ok, load_ok;
  logic              load_acc, store_acc, mem_load, push, pop;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;

  assign fence_active = (state_q == StFence);
  // No pass-through: a full buffer refuses stores even while it drains.
  assign store_ok     = !fence_active && !full;

`ifdef LSU_STORE_FWD_EN
  assign load_ok   = !fence_active && !full;
  assign mem_load  = load_acc && !hit;
  assign load_data = hit ? hit_data : read_data;
`else
  assign load_ok   = !fence_active && !full && !hit;
  assign mem_load  = load_acc;
  assign load_data = read_data;
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

  assign req_ready = req_write ? store_ok : load_ok;
  assign load_acc  = req_valid && !req_write && load_ok;
  assign store_acc = req_valid && req_write && store_ok;

  // A memory load owns the port; otherwise any buffered store drains.
  assign push = store_acc && !reset;
  assign pop  = !empty && !mem_load && !reset;

  assign memRead    = mem_load && !reset;
  assign memWrite   = pop;
  assign address    = memRead ? req_addr : (memWrite ? head_addr : '0);
  assign write_data = memWrite ? head_data : '0;

  assign sb_busy    = !empty || fence_active;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  store_buffer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MATCH_W (MATCH_W),
    .SB_DEPTH(SB_DEPTH)
  ) u_store_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .pop        (pop),
    .lookup_addr(req_addr),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // Fence state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Fence next state: leave one cycle after the buffer is seen empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (drain_req) state_d = StFence;
      StFence: if (empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load response register: one-cycle valid pulse with captured data.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= load_acc;
      if (load_acc) begin
        resp_rdata_q <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a queue-based reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0, req_write = 1'b0, drain_req = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, resp_valid, sb_busy, memWrite, memRead;
  logic [DATA_W-1:0] resp_rdata, write_data, read_data;
  logic [ADDR_W-1:0] address;

  logic [DATA_W-1:0] mem [4096];

  // Reference model state
  sb_entry_t         sbq[$];
  logic [DATA_W-1:0] mmodel [4096];
  bit                fence_m;
  logic              exp_rv;
  logic [DATA_W-1:0] exp_rd;
  bit                rd_chk;
  int                checks = 0;
  int                errors = 0;

  load_store_unit #(.SB_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .drain_req (drain_req),
    .sb_busy   (sb_busy),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 24'h5A0000 ^ DATA_W'(i * 7);
  endfunction

  // Memory decodes the low MATCH_W bits; contents reload while reset is high.
  assign read_data = mem[address[MATCH_W-1:0]];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (memWrite) begin
      mem[address[MATCH_W-1:0]] <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check strobes, advance model.
  task automatic step(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic dr, input logic rst);
    int                n;
    bit                match, rdy, lacc, sacc, mrd, mwr;
    logic [DATA_W-1:0] ydata, ld;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ewd;
    @(negedge clock);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv || rd_chk) chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
    chk("sb_busy", 32'(sb_busy), 32'((sbq.size() > 0) || fence_m));
    rd_chk    = 0;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    drain_req = dr;
    reset     = rst;
    #1;
    if (rst) begin
      chk("memWrite_rst", 32'(memWrite), 32'(0));
      chk("memRead_rst", 32'(memRead), 32'(0));
      sbq.delete();
      for (int i = 0; i < 4096; i++) mmodel[i] = init_word(i);
      fence_m = 0;
      exp_rv  = 1'b0;
      exp_rd  = '0;
      rd_chk  = 1;
    end else begin
      n     = sbq.size();
      match = 0;
      ydata = '0;
      foreach (sbq[i]) begin
        if (sbq[i].addr[MATCH_W-1:0] == a[MATCH_W-1:0]) begin
          match = 1;
          ydata = sbq[i].data;
        end
      end
      if (fence_m) rdy = 0;
      else if (w) rdy = (n < DEPTH);
`ifdef LSU_STORE_FWD_EN
      else rdy = (n < DEPTH);
      mrd = v && !w && rdy && !match;
`else
      else rdy = (n < DEPTH) && !match;
      mrd = v && !w && rdy;
`endif
      lacc = v && !w && rdy;
      sacc = v && w && rdy;
      mwr  = !mrd && (n > 0);
      ea   = '0;
      ewd  = '0;
      if (mrd) ea = a;
      else if (mwr) begin
        ea  = sbq[0].addr;
        ewd = sbq[0].data;
      end
      if (v) chk("req_ready", 32'(req_ready), 32'(rdy));
      chk("memRead", 32'(memRead), 32'(mrd));
      chk("memWrite", 32'(memWrite), 32'(mwr));
      chk("address", 32'(address), 32'(ea));
      chk("write_data", 32'(write_data), 32'(ewd));
      ld = (lacc && !mrd) ? ydata : mmodel[a[MATCH_W-1:0]];
      exp_rv = lacc;
      if (lacc) exp_rd = ld;
      if (mwr) begin
        mmodel[sbq[0].addr[MATCH_W-1:0]] = sbq[0].data;
        void'(sbq.pop_front());
      end
      if (sacc) sbq.push_back('{addr: a, data: d});
      if (!fence_m && dr) fence_m = 1;
      else if (fence_m && n == 0) fence_m = 0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 4096; i++) mmodel[i] = init_word(i);
    fence_m = 0;
    exp_rv  = 1'b0;
    exp_rd  = '0;
    rd_chk  = 1;
    repeat (2) @(posedge clock);

    // Reset while stores are in flight
    step(1'b1, 1'b1, 24'h000200, 24'h111111, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h000300, 24'h222222, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h000400, 24'h333333, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(3);

    // Store then load of the same address
    step(1'b1, 1'b1, 24'h000010, 24'hABCDEF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h000010, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h000010, '0, 1'b0, 1'b0);
    idle(2);

    // Back-to-back stores interleaved with loads to 0x000100
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 24'h000040 + 24'(i), 24'h0C0000 + 24'(i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 24'h000100, '0, 1'b0, 1'b0);
    end
    idle(3);

    // Alias on the low address bits
    step(1'b1, 1'b1, 24'h001020, 24'h123456, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h000020, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h000020, '0, 1'b0, 1'b0);
    idle(2);

    // Fence with buffered stores, requests offered throughout
    step(1'b1, 1'b1, 24'h000030, 24'h0F0F0F, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h000031, 24'hF0F0F0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h000500, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(3);

    // Back-to-back loads from preloaded words
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 24'(i), '0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic over a small aliasing address pool
    for (int i = 0; i < 2000; i++) begin
      ra = (24'($urandom_range(0, 1)) << 12) | (24'($urandom_range(0, 7)) << 4);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
           24'($urandom), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
